// File: rtl/prog_loader_pkg.sv
// Shared definitions for the program loader and the accumulator core control unit:
// memory geometry, the HALT terminator, opcode encodings and loader states.
package prog_loader_pkg;

    localparam int DEPTH = 16;
    localparam int AW    = 4;
    localparam int DW    = 8;

    localparam logic [DW-1:0] HALT_WORD = 8'hFF;

    localparam logic [3:0] OP_SHIFT   = 4'b0000;
    localparam logic [3:0] OP_ADD     = 4'b0001;
    localparam logic [3:0] OP_SUB     = 4'b0010;
    localparam logic [3:0] OP_MUL     = 4'b0011;
    localparam logic [3:0] OP_DIV     = 4'b0100;
    localparam logic [3:0] OP_AND     = 4'b0101;
    localparam logic [3:0] OP_XOR     = 4'b0110;
    localparam logic [3:0] OP_CMP     = 4'b0111;
    localparam logic [3:0] OP_BRANCH  = 4'b1000;
    localparam logic [3:0] OP_MOV_ACC = 4'b1001;
    localparam logic [3:0] OP_MOV_R   = 4'b1010;
    localparam logic [3:0] OP_RETURN  = 4'b1011;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2
    } loader_state_e;

endpackage

// File: rtl/prog_loader_if.sv
// Byte-stream load channel and core fetch port of the program loader.
// The master side is the byte source / core; the slave side is the loader.
interface prog_loader_if;
    import prog_loader_pkg::*;

    logic          in_valid;
    logic [DW-1:0] in_data;
    logic          in_ready;
    logic [AW-1:0] fetch_addr;
    logic [DW-1:0] fetch_instr;

    modport master (
        output in_valid,
        output in_data,
        output fetch_addr,
        input  in_ready,
        input  fetch_instr
    );

    modport slave (
        input  in_valid,
        input  in_data,
        input  fetch_addr,
        output in_ready,
        output fetch_instr
    );
endinterface

// File: rtl/prog_loader_imem_array.sv
// Instruction storage: one synchronous write port, one asynchronous read port.
// Contents are deliberately not reset; the loader gates reads of stale words.
module imem_array #(
    parameter int DEPTH = 16,
    parameter int AW    = 4,
    parameter int DW    = 8
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);
    logic [DW-1:0] mem_r [DEPTH];

    // Write port
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[waddr] <= wdata;
        end
    end

    assign rdata = mem_r[raddr];
endmodule

// File: rtl/prog_loader.sv
// Loads a byte stream into instruction memory and releases the core once a
// HALT-terminated (or full) program is present; fetches return HALT otherwise.
module prog_loader
    import prog_loader_pkg::*;
(
    input  logic         main_clk,
    input  logic         rst_n,
    input  logic         start,
    prog_loader_if.slave bus,
    output logic         core_run,
    output logic [AW:0]  load_count,
    output logic         no_halt_err
);
    localparam logic [AW:0] LAST_IDX = (AW+1)'(DEPTH - 1);

    loader_state_e state_r, state_s;
    logic [AW:0]   count_r, count_s;
    logic          err_r, err_s;
    logic          ready_r, run_r;
    logic          we_s;
    logic [DW-1:0] rdata_s;
    logic [DW-1:0] fetch_s;

    // State, counter and flag registers; in_ready/core_run are registered decodes of the next state
    always_ff @(posedge main_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
            count_r <= '0;
            err_r   <= 1'b0;
            ready_r <= 1'b0;
            run_r   <= 1'b0;
        end else begin
            state_r <= state_s;
            count_r <= count_s;
            err_r   <= err_s;
            ready_r <= (state_s == LOAD);
            run_r   <= (state_s == RUN);
        end
    end

    // Next-state logic; a byte is only taken while in LOAD, so in_data is never looked at otherwise
    always_comb begin
        state_s = state_r;
        count_s = count_r;
        err_s   = err_r;
        we_s    = 1'b0;
        case (state_r)
            IDLE, RUN: begin
                if (start) begin
                    state_s = LOAD;
                    count_s = '0;
                    err_s   = 1'b0;
                end else begin
                    state_s = state_r;
                end
            end
            LOAD: begin
                if (bus.in_valid) begin
                    we_s    = 1'b1;
                    count_s = count_r + (AW+1)'(1);
                    if (bus.in_data == HALT_WORD) begin
                        state_s = RUN;
                    end else if (count_r == LAST_IDX) begin
                        state_s = RUN;
                        err_s   = 1'b1;
                    end else begin
                        state_s = LOAD;
                    end
                end else begin
                    state_s = LOAD;
                end
            end
            default: begin
                state_s = IDLE;
                count_s = '0;
                err_s   = 1'b0;
            end
        endcase
    end

    imem_array #(
        .DEPTH (DEPTH),
        .AW    (AW),
        .DW    (DW)
    ) u_imem (
        .clk   (main_clk),
        .we    (we_s),
        .waddr (count_r[AW-1:0]),
        .wdata (bus.in_data),
        .raddr (bus.fetch_addr),
        .rdata (rdata_s)
    );

    // Only words written by the current program are visible to the core
    always_comb begin
        if ((state_r == RUN) && ({1'b0, bus.fetch_addr} < count_r)) begin
            fetch_s = rdata_s;
        end else begin
            fetch_s = HALT_WORD;
        end
    end

    assign bus.fetch_instr = fetch_s;
    assign bus.in_ready    = ready_r;
    assign core_run        = run_r;
    assign load_count      = count_r;
    assign no_halt_err     = err_r;
endmodule

// File: tb/tb_prog_loader.sv
// Self-checking bench for prog_loader: directed scenarios plus randomized loads
// compared against a program-level reference model.
module tb_prog_loader;

    logic       main_clk;
    logic       rst_n;
    logic       start;
    logic       core_run;
    logic [4:0] load_count;
    logic       no_halt_err;

    prog_loader_if bus ();

    prog_loader dut (
        .main_clk    (main_clk),
        .rst_n       (rst_n),
        .start       (start),
        .bus         (bus),
        .core_run    (core_run),
        .load_count  (load_count),
        .no_halt_err (no_halt_err)
    );

    initial main_clk = 1'b0;
    always #5 main_clk = ~main_clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: program contents and loader status
    logic [7:0] m_prog [16];
    int         m_len;
    bit         m_loading;
    bit         m_running;
    bit         m_err;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_len     = 0;
        m_loading = 1'b0;
        m_running = 1'b0;
        m_err     = 1'b0;
    endtask

    // One clock cycle: drive inputs, apply the edge to the model, compare status
    task automatic cycle(input bit st, input bit vld, input logic [7:0] dat);
        start        = st;
        bus.in_valid = vld;
        bus.in_data  = dat;
        @(posedge main_clk);
        #1;
        if (m_loading) begin
            if (vld) begin
                m_prog[m_len] = dat;
                m_len++;
                if (dat == 8'hFF) begin
                    m_loading = 1'b0;
                    m_running = 1'b1;
                end else if (m_len == 16) begin
                    m_loading = 1'b0;
                    m_running = 1'b1;
                    m_err     = 1'b1;
                end
            end
        end else if (st) begin
            m_loading = 1'b1;
            m_running = 1'b0;
            m_len     = 0;
            m_err     = 1'b0;
        end
        chk("in_ready", bus.in_ready, m_loading);
        chk("core_run", core_run, m_running);
        chk("load_count", load_count, m_len);
        chk("no_halt_err", no_halt_err, m_err);
        start        = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data  = 8'($urandom);
    endtask

    // Walk every fetch address with the loader quiescent
    task automatic sweep(input string tag);
        logic [7:0] exp;
        for (int a = 0; a < 16; a++) begin
            @(negedge main_clk);
            bus.fetch_addr = 4'(a);
            #1;
            exp = (m_running && a < m_len) ? m_prog[a] : 8'hFF;
            chk(tag, bus.fetch_instr, exp);
        end
        @(posedge main_clk);
        #1;
    endtask

    task automatic fetch_at(input string tag, input logic [3:0] addr, input logic [7:0] exp);
        bus.fetch_addr = addr;
        #1;
        chk(tag, bus.fetch_instr, exp);
    endtask

    logic [7:0] prog_a [7];
    int         ready_cycles;

    initial begin
        prog_a = '{8'h91, 8'h61, 8'h93, 8'h81, 8'hA1, 8'hB0, 8'hFF};
        start          = 1'b0;
        bus.in_valid   = 1'b0;
        bus.in_data    = 8'h00;
        bus.fetch_addr = 4'd0;
        rst_n          = 1'b0;
        model_reset();
        #12;
        chk("rst_fetch", bus.fetch_instr, 8'hFF);
        chk("rst_run", core_run, 1'b0);
        chk("rst_ready", bus.in_ready, 1'b0);
        chk("rst_count", load_count, 5'd0);
        @(negedge main_clk);
        rst_n = 1'b1;
        @(posedge main_clk);
        #1;

        // Back-to-back seven-byte program
        cycle(1'b1, 1'b0, 8'h00);
        ready_cycles = 0;
        for (int i = 0; i < 7; i++) begin
            if (bus.in_ready) ready_cycles++;
            cycle(1'b0, 1'b1, prog_a[i]);
        end
        chk("ready_cycles", ready_cycles, 7);
        chk("a_count", load_count, 5'd7);
        chk("a_run", core_run, 1'b1);
        sweep("a_fetch");
        fetch_at("a_fetch5", 4'd5, 8'hB0);
        fetch_at("a_fetch7", 4'd7, 8'hFF);

        // Same program with a three-cycle gap after byte 2
        cycle(1'b1, 1'b0, 8'h00);
        for (int i = 0; i < 7; i++) begin
            if (i == 2) begin
                for (int g = 0; g < 3; g++) begin
                    cycle(1'b0, 1'b0, 8'($urandom));
                    chk("gap_count", load_count, 5'd2);
                end
            end
            cycle(1'b0, 1'b1, prog_a[i]);
        end
        chk("b_count", load_count, 5'd7);
        sweep("b_fetch");

        // Full sixteen-word program with no terminator
        cycle(1'b1, 1'b0, 8'h00);
        for (int i = 0; i < 16; i++) begin
            cycle(1'b0, 1'b1, 8'(8'h10 + i));
        end
        chk("full_count", load_count, 5'd16);
        chk("full_err", no_halt_err, 1'b1);
        chk("full_run", core_run, 1'b1);
        fetch_at("full_fetch15", 4'd15, 8'h1F);
        sweep("full_fetch");

        // start together with a byte while running: byte is not taken
        cycle(1'b1, 1'b1, 8'h20);
        chk("sim_run", core_run, 1'b0);
        chk("sim_count", load_count, 5'd0);
        fetch_at("sim_fetch0", 4'd0, 8'hFF);
        cycle(1'b0, 1'b1, 8'hFF);
        chk("sim_len", load_count, 5'd1);
        sweep("sim_fetch");

        // Asynchronous reset three bytes into a load
        cycle(1'b1, 1'b0, 8'h00);
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 8'(8'h40 + i));
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("arst_ready", bus.in_ready, 1'b0);
        chk("arst_run", core_run, 1'b0);
        chk("arst_count", load_count, 5'd0);
        chk("arst_err", no_halt_err, 1'b0);
        fetch_at("arst_fetch0", 4'd0, 8'hFF);
        @(negedge main_clk);
        rst_n = 1'b1;
        @(posedge main_clk);
        #1;
        sweep("arst_sweep");

        // Randomized loads: random bytes, valid gaps and ignored start pulses
        for (int t = 0; t < 20; t++) begin
            cycle(1'b1, 1'b0, 8'($urandom));
            for (int k = 0; k < 200 && m_loading; k++) begin
                logic [7:0] d;
                d = ($urandom_range(0, 9) == 0) ? 8'hFF : 8'($urandom_range(0, 254));
                cycle(($urandom_range(0, 9) == 0), ($urandom_range(0, 9) < 7), d);
            end
            chk("rnd_done", m_loading, 1'b0);
            sweep("rnd_fetch");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
